// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit common-anode 7-segment scan driver.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Segment bytes are active low, ordered {dp,g,f,e,d,c,b,a}; all patterns have dp off.
package seg7_pkg;

    // Bit positions inside a segment byte.
    localparam int SEG_BIT_A  = 0;
    localparam int SEG_BIT_B  = 1;
    localparam int SEG_BIT_C  = 2;
    localparam int SEG_BIT_D  = 3;
    localparam int SEG_BIT_E  = 4;
    localparam int SEG_BIT_F  = 5;
    localparam int SEG_BIT_G  = 6;
    localparam int SEG_BIT_DP = 7;

    // Hex glyphs, active low, dp off.
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    // All segments dark / all digit enables off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] AN_OFF    = 8'hFF;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display bus between the display-source mux and the scan driver.
// Latency: n/a (wiring only).
// Backpressure: none; the driver samples the source once per frame.
//
// Signals: disp_num[31:0] (nibble i -> digit i), point_in[7:0] (dp per digit),
// blink_in[7:0] (blink per digit), an[7:0] (digit enables, active low),
// seg[7:0] (segments, active low), frame_start (pulse at digit-0 dead cycle).
interface seg7_scan_driver_if;

    logic [31:0] disp_num;
    logic [7:0]  point_in;
    logic [7:0]  blink_in;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_start;

    // Source side: drives the display word and masks, may watch the pins.
    modport master (
        output disp_num,
        output point_in,
        output blink_in,
        input  an,
        input  seg,
        input  frame_start
    );

    // Driver side.
    modport slave (
        input  disp_num,
        input  point_in,
        input  blink_in,
        output an,
        output seg,
        output frame_start
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Hex nibble plus decimal point to active-low 7-segment byte.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports: i_nib[3:0] nibble, i_dp (1 = dp lit), o_seg[7:0] {dp,g,f,e,d,c,b,a} active low.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
        o_seg[SEG_BIT_DP] = ~i_dp;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment driver with per-frame input snapshot and blink.
// Latency: an/seg/frame_start registered, 1 cycle after counter state; new inputs show in the next frame.
// Backpressure: none; inputs are sampled only at the frame boundary, never stalled.
//
// Ports: clk, rst (sync, active high), bus (slave modport: disp_num/point_in/blink_in in,
// an/seg/frame_start out).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_scan_driver_if.slave    bus
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_digit;
    logic [FRM_W-1:0] r_frm_cnt;
    logic             r_phase;
    logic [31:0]      r_num_q;
    logic [7:0]       r_pt_q;
    logic [7:0]       r_bl_q;
    logic [7:0]       r_an;
    logic [7:0]       r_seg;
    logic             r_frame_start;

    logic             w_slot_end;
    logic             w_frame_end;
    logic             w_frm_wrap;
    logic             w_dead;
    logic             w_blank;
    logic [3:0]       w_nib;
    logic [7:0]       w_seg;
    logic [7:0]       w_an_lit;

    assign w_slot_end  = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
    assign w_frame_end = w_slot_end && (r_digit == 3'd7);
    assign w_frm_wrap  = (r_frm_cnt == FRM_W'(BLINK_FRAMES - 1));

    // First cycle of every slot is dark so the previous digit's ghost never shows on the new anode.
    assign w_dead   = (r_div_cnt == '0);
    assign w_blank  = r_phase & r_bl_q[r_digit];
    assign w_nib    = 4'(r_num_q >> {r_digit, 2'b00});
    assign w_an_lit = ~(8'b1 << r_digit);

    hex_to_seg7 u_dec (
        .i_nib (w_nib),
        .i_dp  (r_pt_q[r_digit]),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt     <= '0;
            r_digit       <= 3'd0;
            r_frm_cnt     <= '0;
            r_phase       <= 1'b0;
            r_num_q       <= 32'd0;
            r_pt_q        <= 8'd0;
            r_bl_q        <= 8'd0;
            r_an          <= AN_OFF;
            r_seg         <= SEG_BLANK;
            r_frame_start <= 1'b0;
        end else begin
            r_div_cnt <= w_slot_end ? '0 : r_div_cnt + DIV_W'(1);
            if (w_slot_end) begin
                r_digit <= r_digit + 3'd1;
            end

            // Snapshot and blink phase move together so a frame is always self-consistent.
            if (w_frame_end) begin
                r_num_q   <= bus.disp_num;
                r_pt_q    <= bus.point_in;
                r_bl_q    <= bus.blink_in;
                r_frm_cnt <= w_frm_wrap ? '0 : r_frm_cnt + FRM_W'(1);
                if (w_frm_wrap) begin
                    r_phase <= ~r_phase;
                end
            end

            // seg keeps driving the new digit's glyph during the dark cycle; only an is gated.
            r_an          <= (w_dead || w_blank) ? AN_OFF : w_an_lit;
            r_seg         <= w_seg;
            r_frame_start <= w_dead && (r_digit == 3'd0);
        end
    end

    assign bus.an          = r_an;
    assign bus.seg         = r_seg;
    assign bus.frame_start = r_frame_start;

endmodule
